// File: rtl/wishbone_to_ahb.sv
// wishbone_to_ahb: Wishbone classic slave to AHB-Lite master bridge.
// Issues one non-pipelined AHB transfer at a time. Writes whose byte strobes
// are not a word, an aligned half or a single byte go out as a series of
// byte transfers, lowest lane first.
// Optional feature macro: WB2AHB_ERR_EN (adds wb_err, reports AHB errors).
module wishbone_to_ahb #(
   parameter int          ADDR_WIDTH  = 32,
   parameter int          DATA_WIDTH  = 32,
   parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   input  logic [3:0]            wb_wstrb,
   input  logic [ADDR_WIDTH-1:0] wb_adr,
   input  logic [DATA_WIDTH-1:0] wb_dat_w,
   output logic [DATA_WIDTH-1:0] wb_dat_r,
   output logic                  wb_ack,
`ifdef WB2AHB_ERR_EN
   output logic                  wb_err,
`endif
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic                  HMASTLOCK,
   output logic [DATA_WIDTH-1:0] HWDATA,
   input  logic [DATA_WIDTH-1:0] HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ACK} state_t;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_haddr;
   logic [1:0]              r_htrans;
   logic                    r_hwrite;
   logic [2:0]              r_hsize;
   logic [DATA_WIDTH-1:0]   r_hwdata;
   logic [DATA_WIDTH-1:0]   r_dat_r;
   logic                    r_ack;
   logic                    r_err;
   logic [3:0]              r_mask;   // remaining lanes of a split write
   logic                    r_abort;  // wb_cyc dropped while a transfer was in flight

   logic [2:0]              w_size;
   logic [1:0]              w_lo;
   logic                    w_split;
   logic [3:0]              w_rem;
   logic [1:0]              w_next_lo;
   logic                    w_abort;
   logic                    w_err_rsp;
   logic                    w_unused;

   // lowest set lane of a strobe mask
   function automatic logic [1:0] f_lowest(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // decode the incoming request into transfer size, low address bits, split
   always_comb begin
      w_size  = 3'd2;
      w_lo    = 2'b00;
      w_split = 1'b0;
      if (wb_we) begin
         case (wb_wstrb)
            4'b1111, 4'b0000: ;
            4'b0011: begin w_size = 3'd1; w_lo = 2'b00; end
            4'b1100: begin w_size = 3'd1; w_lo = 2'b10; end
            4'b0001: begin w_size = 3'd0; w_lo = 2'd0; end
            4'b0010: begin w_size = 3'd0; w_lo = 2'd1; end
            4'b0100: begin w_size = 3'd0; w_lo = 2'd2; end
            4'b1000: begin w_size = 3'd0; w_lo = 2'd3; end
            default: begin w_size = 3'd0; w_lo = f_lowest(wb_wstrb); w_split = 1'b1; end
         endcase
      end
   end

   // lanes still owed after the byte currently in its data phase
   assign w_rem     = r_mask & ~(4'b0001 << r_haddr[1:0]);
   assign w_next_lo = f_lowest(w_rem);
   assign w_abort   = r_abort | ~wb_cyc;
`ifdef WB2AHB_ERR_EN
   assign w_err_rsp = HRESP;
`else
   assign w_err_rsp = 1'b0;
`endif
   // byte lanes come only from the strobes, so the low address bits are dropped
   assign w_unused  = ^wb_adr[1:0];

   // bridge FSM with all bus outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_haddr  <= '0;
         r_htrans <= TR_IDLE;
         r_hwrite <= 1'b0;
         r_hsize  <= 3'd0;
         r_hwdata <= '0;
         r_dat_r  <= '0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_mask   <= 4'b0000;
         r_abort  <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (wb_cyc && wb_stb) begin
                  r_abort <= 1'b0;
                  if (wb_we) r_hwdata <= wb_dat_w;
                  if (wb_we && wb_wstrb == 4'b0000) begin
                     r_state <= S_ACK;
                     r_ack   <= 1'b1;
                  end else begin
                     r_state  <= S_ADDR;
                     r_htrans <= TR_NONSEQ;
                     r_haddr  <= {wb_adr[ADDR_WIDTH-1:2], w_lo};
                     r_hsize  <= w_size;
                     r_hwrite <= wb_we;
                     r_mask   <= w_split ? wb_wstrb : 4'b0000;
                  end
               end
            end
            S_ADDR: begin
               // a NONSEQ already on the bus must be carried through
               if (!wb_cyc) r_abort <= 1'b1;
               if (HREADY) begin
                  r_state  <= S_DATA;
                  r_htrans <= TR_IDLE;
               end
            end
            S_DATA: begin
               if (HREADY) begin
                  if (!r_hwrite && !w_err_rsp) r_dat_r <= HRDATA;
                  if (w_abort) begin
                     r_state <= S_IDLE;
                     r_mask  <= 4'b0000;
                  end else if (!HRESP && w_rem != 4'b0000) begin
                     r_state  <= S_ADDR;
                     r_htrans <= TR_NONSEQ;
                     r_haddr  <= {r_haddr[ADDR_WIDTH-1:2], w_next_lo};
                     r_mask   <= w_rem;
                  end else begin
                     r_state <= S_ACK;
                     r_mask  <= 4'b0000;
                     if (w_err_rsp) r_err <= 1'b1;
                     else           r_ack <= 1'b1;
                  end
               end else if (!wb_cyc) begin
                  r_abort <= 1'b1;
               end
            end
            S_ACK: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wb_dat_r  = r_dat_r;
   assign wb_ack    = r_ack;
`ifdef WB2AHB_ERR_EN
   assign wb_err    = r_err;
`endif
   assign HADDR     = r_haddr;
   assign HTRANS    = r_htrans;
   assign HWRITE    = r_hwrite;
   assign HSIZE     = r_hsize;
   assign HWDATA    = r_hwdata;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VALUE;
   assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_wishbone_to_ahb.sv
// tb_wishbone_to_ahb: directed vector bench for the Wishbone to AHB bridge.
module tb_wishbone_to_ahb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic        wb_err;
   logic [3:0]  wb_wstrb;
   logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   wishbone_to_ahb dut (
      .clk(clk), .rst(rst),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_wstrb(wb_wstrb),
      .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
`ifdef WB2AHB_ERR_EN
      .wb_err(wb_err),
`endif
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

`ifndef WB2AHB_ERR_EN
   assign wb_err = 1'b0;
`endif

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] rdata;
      int          waits;
      int          exp_n;
      logic [31:0] exp_a0;
      logic [31:0] exp_a1;
      logic [2:0]  exp_sz;
      int          exp_ack_k;
      logic [31:0] exp_dat_r;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Drives one Wishbone request and plays a simple AHB slave for 20 cycles.
   // Cycle k is the k-th negedge after the edge that samples the request.
   task automatic run_txn(input logic we, input logic [3:0] wstrb, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [31:0] rdata, input int waits,
                          input bit err, input int drop_k,
                          output int ntrans, output int ack_k, output int ack_n, output int err_n,
                          output logic [31:0] a0, output logic [31:0] a1,
                          output logic [2:0] sz, output bit hw_ok);
      bit dph = 0;
      int dwait = 0;
      ntrans = 0; ack_k = 0; ack_n = 0; err_n = 0;
      a0 = '0; a1 = '0; sz = '0; hw_ok = 1;
      wb_cyc = 1; wb_stb = 1; wb_we = we; wb_wstrb = wstrb; wb_adr = adr; wb_dat_w = dat;
      HREADY = 1; HRESP = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (wb_ack) begin ack_n++; if (ack_k == 0) ack_k = k; end
         if (wb_err) err_n++;
         if (wb_ack || wb_err || k == drop_k) begin wb_cyc = 0; wb_stb = 0; end
         if (dph) begin
            if (we && HWDATA !== dat) hw_ok = 0;
            HRESP = err;
            if (dwait > 0) begin HREADY = 0; dwait--; end
            else begin HREADY = 1; HRDATA = rdata; dph = 0; end
         end else if (HTRANS == 2'b10) begin
            if (ntrans == 0) begin a0 = HADDR; sz = HSIZE; end
            if (ntrans == 1) a1 = HADDR;
            ntrans++;
            HREADY = 1; HRESP = 0; dph = 1; dwait = waits;
         end else begin
            HREADY = 1; HRESP = 0;
         end
      end
   endtask

   int ntrans, ack_k, ack_n, err_n;
   logic [31:0] a0, a1;
   logic [2:0] sz;
   bit hw_ok;

   initial begin
      //            we  strb     adr         dat           rdata         w  n  a0          a1          sz ack dat_r
      tbl[0] = '{1'b0, 4'b0000, 32'h100, 32'h0,         32'hDEADBEEF, 0, 1, 32'h100, 32'h0,   3'd2, 3, 32'hDEADBEEF};
      tbl[1] = '{1'b1, 4'b1100, 32'h204, 32'hAABB0000, 32'h0,         2, 1, 32'h206, 32'h0,   3'd1, 5, 32'hDEADBEEF};
      tbl[2] = '{1'b1, 4'b0101, 32'h40,  32'h00110022, 32'h0,         0, 2, 32'h40,  32'h42,  3'd0, 5, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 4'b0000, 32'h80,  32'h0BADBAD0, 32'h0,         0, 0, 32'h0,   32'h0,   3'd0, 1, 32'hDEADBEEF};
      tbl[4] = '{1'b1, 4'b1111, 32'h303, 32'h12345678, 32'h0,         1, 1, 32'h300, 32'h0,   3'd2, 4, 32'hDEADBEEF};
      tbl[5] = '{1'b1, 4'b0011, 32'h10,  32'h00005566, 32'h0,         0, 1, 32'h10,  32'h0,   3'd1, 3, 32'hDEADBEEF};
      tbl[6] = '{1'b1, 4'b1000, 32'h20,  32'h77000000, 32'h0,         0, 1, 32'h23,  32'h0,   3'd0, 3, 32'hDEADBEEF};
      tbl[7] = '{1'b1, 4'b1011, 32'h50,  32'hA1B2C3D4, 32'h0,         0, 3, 32'h50,  32'h51,  3'd0, 7, 32'hDEADBEEF};
      tbl[8] = '{1'b0, 4'b1111, 32'h1FE, 32'h0,         32'hCAFEF00D, 1, 1, 32'h1FC, 32'h0,   3'd2, 4, 32'hCAFEF00D};
      tbl[9] = '{1'b1, 4'b0100, 32'h33,  32'h00990000, 32'h0,         0, 1, 32'h32,  32'h0,   3'd0, 3, 32'hCAFEF00D};

      wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_wstrb = 0; wb_adr = 0; wb_dat_w = 0;
      HRDATA = 0; HREADY = 1; HRESP = 0;

      // reset values
      #12;
      chk("rst HTRANS", 32'(HTRANS), 32'h0);
      chk("rst HADDR", HADDR, 32'h0);
      chk("rst HSIZE", 32'(HSIZE), 32'h0);
      chk("rst HWRITE", 32'(HWRITE), 32'h0);
      chk("rst HWDATA", HWDATA, 32'h0);
      chk("rst wb_ack", 32'(wb_ack), 32'h0);
      chk("rst wb_err", 32'(wb_err), 32'h0);
      chk("rst wb_dat_r", wb_dat_r, 32'h0);
      chk("rst HPROT", 32'(HPROT), 32'h3);
      chk("rst HBURST", 32'(HBURST), 32'h0);
      chk("rst HMASTLOCK", 32'(HMASTLOCK), 32'h0);
      @(negedge clk);
      rst = 0;

      // table of single Wishbone cycles
      for (int i = 0; i < 10; i++) begin
         run_txn(tbl[i].we, tbl[i].wstrb, tbl[i].adr, tbl[i].dat, tbl[i].rdata, tbl[i].waits,
                 1'b0, 0, ntrans, ack_k, ack_n, err_n, a0, a1, sz, hw_ok);
         chk($sformatf("v%0d ntrans", i), 32'(ntrans), 32'(tbl[i].exp_n));
         if (tbl[i].exp_n > 0) begin
            chk($sformatf("v%0d HADDR0", i), a0, tbl[i].exp_a0);
            chk($sformatf("v%0d HSIZE", i), 32'(sz), 32'(tbl[i].exp_sz));
         end
         if (tbl[i].exp_n > 1) chk($sformatf("v%0d HADDR1", i), a1, tbl[i].exp_a1);
         chk($sformatf("v%0d ack_cycle", i), 32'(ack_k), 32'(tbl[i].exp_ack_k));
         chk($sformatf("v%0d ack_count", i), 32'(ack_n), 32'h1);
         chk($sformatf("v%0d wb_dat_r", i), wb_dat_r, tbl[i].exp_dat_r);
         chk($sformatf("v%0d HWDATA_stable", i), 32'(hw_ok), 32'h1);
      end

      // wb_cyc dropped during the first data phase of a split write
      run_txn(1'b1, 4'b1011, 32'h60, 32'h01020304, 32'h0, 0, 1'b0, 2,
              ntrans, ack_k, ack_n, err_n, a0, a1, sz, hw_ok);
      chk("drop ntrans", 32'(ntrans), 32'h1);
      chk("drop HADDR0", a0, 32'h60);
      chk("drop ack_count", 32'(ack_n), 32'h0);

      // two-cycle AHB error on a read
      run_txn(1'b0, 4'b0000, 32'h400, 32'h0, 32'h11111111, 1, 1'b1, 0,
              ntrans, ack_k, ack_n, err_n, a0, a1, sz, hw_ok);
      chk("err ntrans", 32'(ntrans), 32'h1);
`ifdef WB2AHB_ERR_EN
      chk("err err_count", 32'(err_n), 32'h1);
      chk("err ack_count", 32'(ack_n), 32'h0);
      chk("err wb_dat_r", wb_dat_r, 32'hCAFEF00D);
`else
      chk("err ack_count", 32'(ack_n), 32'h1);
      chk("err ack_cycle", 32'(ack_k), 32'h4);
      chk("err wb_dat_r", wb_dat_r, 32'h11111111);
`endif

      // reset asserted during a waited address phase
      wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_wstrb = 0; wb_adr = 32'h500; HREADY = 0;
      @(negedge clk);
      chk("rstmid NONSEQ", 32'(HTRANS), 32'h2);
      #2 rst = 1;
      #1;
      chk("rstmid HTRANS", 32'(HTRANS), 32'h0);
      chk("rstmid wb_ack", 32'(wb_ack), 32'h0);
      wb_cyc = 0; wb_stb = 0;
      @(negedge clk);
      chk("rstmid held", 32'(HTRANS), 32'h0);
      rst = 0; HREADY = 1;
      run_txn(1'b0, 4'b0000, 32'h600, 32'h0, 32'h600DF00D, 0, 1'b0, 0,
              ntrans, ack_k, ack_n, err_n, a0, a1, sz, hw_ok);
      chk("post ntrans", 32'(ntrans), 32'h1);
      chk("post HADDR0", a0, 32'h600);
      chk("post ack_cycle", 32'(ack_k), 32'h3);
      chk("post ack_count", 32'(ack_n), 32'h1);
      chk("post wb_dat_r", wb_dat_r, 32'h600DF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
